instr_exec_reader: RTL and testbench
====================================

Name: instr_exec_reader

Overview:
- Read-side consumer of the instruction register stack: walks read_pointer over a programmed address range and fetches each instruction_word.
- Executes each opcode on op_a/op_b and presents one result per instruction on a valid/ready output port.
- Sits between the instruction register and the downstream result checker/scoreboard; it is the reader counterpart of the stimulus writer.

Parameters:
- RES_W, 64, result width; sign-extended, holds a full 32x32 signed product.
- DEPTH, 32, register stack depth; read_pointer wraps modulo DEPTH.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; accepted only in IDLE.
- first_addr  in  address_t (5)  first register location to read.
- count  in  6  instructions in the run, 0..32.
- read_pointer  out  address_t (5)  address driven to the instruction register.
- instruction_word  in  instruction_t  {opc, op_a, op_b} returned for read_pointer.
- result  out  RES_W  signed execution result.
- result_addr  out  address_t  location the current result came from.
- result_valid  out  1  result/result_addr/flags valid.
- result_ready  in  1  downstream accepts the result.
- err_div0  out  1  current result came from DIV/MOD with op_b==0.
- err_illegal  out  1  current result came from an opc outside 0..7.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (sync, active-high) values: read_pointer=0, result=0, result_addr=0, result_valid=0, err_div0=0, err_illegal=0, busy=0, done=0, state=IDLE. Reset asserted mid-run aborts the run; there is no done pulse and no result is emitted.
- States: IDLE, FETCH, EXEC, OUT, DONE.
- IDLE:
  - start=1 and count>0: read_pointer<=first_addr, remaining<=count, go to FETCH.
  - start=1 and count=0: go to DONE directly; no reads, no results.
- FETCH: read_pointer is held stable for one cycle so a registered-read register file also works; go to EXEC.
- EXEC: capture instruction_word, compute, register result, result_addr<=read_pointer and the flags, set result_valid<=1, go to OUT.
- OUT: result, result_addr and flags are held stable while result_valid=1 and result_ready=0. The handshake completes on a posedge with result_valid=1 and result_ready=1; on that edge:
  - result_valid<=0 and remaining decrements.
  - If remaining==1: go to DONE.
  - Otherwise: read_pointer<=read_pointer+1 (mod DEPTH, 31 wraps to 0), go to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in the DONE cycle's successor.
- start is ignored outside IDLE, including during the DONE cycle.
- Latency: start to first result_valid is 3 cycles (FETCH, EXEC, then valid). Peak throughput is one result per 3 cycles with result_ready tied high.
- Arithmetic: op_a and op_b are signed 32-bit, sign-extended to RES_W before the operation.
  - ZERO -> 0; PASSA -> op_a; PASSB -> op_b.
  - ADD -> op_a+op_b; SUB -> op_a-op_b; MULT -> full signed product.
  - DIV -> op_a/op_b, truncating toward zero.
  - MOD -> op_a%op_b, sign follows op_a.
  - DIV/MOD with op_b==0 -> result=0, err_div0=1.
  - opc 8..15 -> result=0, err_illegal=1.
  - Both flags are 0 for all other cases.
- count=32 with first_addr=5 reads locations 5..31, then 0..4. Each location is read exactly once.

Decomposition:
- instr_register_pkg already holds opcode_t, operand_t, address_t and instruction_t. Add to it:
  - result_t (signed [RES_W-1:0]).
  - exec_state_t enum {IDLE, FETCH, EXEC, OUT, DONE}.
  - Constant ILLEGAL_OPC_MIN=8.
- Sub-module instr_alu: purely combinational; inputs instruction_t, outputs result_t, div0 and illegal. The FSM and pointer/counter logic stay in instr_exec_reader.

Test Plan:
- Reset, then start with first_addr=0, count=3, result_ready=1; stack[0]={ADD,5,7}, [1]={SUB,3,10}, [2]={MULT,-4,6}. Required: results 12, -7, -24 with result_addr 0,1,2; first result_valid 3 cycles after start; done pulses once; busy falls the cycle after done.
- Backpressure: result_ready=0 for 5 cycles with stack[0]={PASSA,9,1}. Required: result=9 and result_valid held stable all 5 cycles; read_pointer does not advance until the handshake.
- Error cases: stack[4]={DIV,-15,0} and stack[5]={MOD,-15,4}. Required: first result 0 with err_div0=1; second result -3 with both flags 0. A word with opc=4'hC returns 0 with err_illegal=1.
- Wrap-around: first_addr=30, count=4. Required: read_pointer sequence 30, 31, 0, 1 and 4 results.
- count=0 start. Required: done one cycle later, result_valid never asserted. A start pulse applied while busy is ignored and the run length is unchanged.
- Reset asserted during OUT of the 2nd of 3 instructions. Required: next edge gives result_valid=0, busy=0, read_pointer=0, no done pulse; a fresh run afterwards completes normally.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register stack and its execution reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_register_pkg;

    localparam int RES_W = 64;
    localparam int DEPTH = 32;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [RES_W-1:0] result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

    // Encodings at or above this value have no defined operation.
    localparam logic [3:0] ILLEGAL_OPC_MIN = 4'd8;

endpackage

// File: rtl/instr_alu.sv
// Executes one instruction word on sign-extended 32-bit operands.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to capture the outputs.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      res,
    output logic         div0,
    output logic         illegal
);

    result_t    a_ext;
    result_t    b_ext;
    result_t    b_safe;
    logic [3:0] opc_bits;
    logic       b_zero;

    assign a_ext    = {{(RES_W-32){instr.op_a[31]}}, instr.op_a};
    assign b_ext    = {{(RES_W-32){instr.op_b[31]}}, instr.op_b};
    assign b_zero   = (instr.op_b == '0);
    // Divisor forced non-zero so the divider never sees 0; the result is discarded then.
    assign b_safe   = b_zero ? result_t'(1) : b_ext;
    assign opc_bits = instr.opc;

    // Opcode decode; SV signed / and % truncate toward zero with remainder sign of op_a.
    always_comb begin
        res     = '0;
        div0    = 1'b0;
        illegal = 1'b0;
        if (opc_bits >= ILLEGAL_OPC_MIN) begin
            illegal = 1'b1;
        end else begin
            case (instr.opc)
                ZERO:  res = '0;
                PASSA: res = a_ext;
                PASSB: res = b_ext;
                ADD:   res = a_ext + b_ext;
                SUB:   res = a_ext - b_ext;
                MULT:  res = a_ext * b_ext;
                DIV: begin
                    if (b_zero) div0 = 1'b1;
                    else        res  = a_ext / b_safe;
                end
                MOD: begin
                    if (b_zero) div0 = 1'b1;
                    else        res  = a_ext % b_safe;
                end
                default: res = '0;
            endcase
        end
    end

endmodule

// File: rtl/instr_exec_reader.sv
// Walks read_pointer over a programmed range, executes each word, emits one result per word.
// Latency: start to first result_valid is 3 cycles; one result per 3 cycles at best.
// Backpressure: result and flags hold while result_valid && !result_ready; pointer waits for the handshake.
module instr_exec_reader
    import instr_register_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  address_t                first_addr,
    input  logic [5:0]              count,
    output address_t                read_pointer,
    input  instruction_t            instruction_word,
    output logic signed [RES_W-1:0] result,
    output address_t                result_addr,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    err_div0,
    output logic                    err_illegal,
    output logic                    busy,
    output logic                    done
);

    exec_state_t state_q, state_d;
    address_t    rp_q, rp_d;
    logic [5:0]  rem_q, rem_d;
    result_t     res_q, res_d;
    address_t    raddr_q, raddr_d;
    logic        vld_q, vld_d;
    logic        div0_q, div0_d;
    logic        ill_q, ill_d;

    result_t     alu_res;
    logic        alu_div0;
    logic        alu_ill;
    address_t    rp_next;

    instr_alu u_alu (
        .instr   (instruction_word),
        .res     (alu_res),
        .div0    (alu_div0),
        .illegal (alu_ill)
    );

    assign rp_next = (rp_q == address_t'(DEPTH - 1)) ? '0 : rp_q + 5'd1;

    // Run sequencing: next state plus pointer, counter and result register updates.
    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        rem_d   = rem_q;
        res_d   = res_q;
        raddr_d = raddr_q;
        vld_d   = vld_q;
        div0_d  = div0_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != 6'd0) begin
                        rp_d    = first_addr;
                        rem_d   = count;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            // Pointer held one extra cycle so a registered-read stack has its data ready.
            FETCH: state_d = EXEC;
            EXEC: begin
                res_d   = alu_res;
                raddr_d = rp_q;
                div0_d  = alu_div0;
                ill_d   = alu_ill;
                vld_d   = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (result_ready) begin
                    vld_d = 1'b0;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        state_d = DONE;
                    end else begin
                        rp_d    = rp_next;
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rp_q    <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            raddr_q <= '0;
            vld_q   <= 1'b0;
            div0_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            raddr_q <= raddr_d;
            vld_q   <= vld_d;
            div0_q  <= div0_d;
            ill_q   <= ill_d;
        end
    end

    assign read_pointer = rp_q;
    assign result       = res_q;
    assign result_addr  = raddr_q;
    assign result_valid = vld_q;
    assign err_div0     = div0_q;
    assign err_illegal  = ill_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_instr_exec_reader.sv
// Directed bench for instr_exec_reader with a combinational-read instruction stack.
// Latency: n/a.
// Backpressure: result_ready driven per test.
module tb_instr_exec_reader;
    import instr_register_pkg::*;

    logic                    clk;
    logic                    reset;
    logic                    start;
    address_t                first_addr;
    logic [5:0]              count;
    address_t                read_pointer;
    instruction_t            instruction_word;
    logic signed [RES_W-1:0] result;
    address_t                result_addr;
    logic                    result_valid;
    logic                    result_ready;
    logic                    err_div0;
    logic                    err_illegal;
    logic                    busy;
    logic                    done;

    instruction_t stack [DEPTH];

    int checks = 0;
    int errors = 0;

    instr_exec_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result           (result),
        .result_addr      (result_addr),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .err_div0         (err_div0),
        .err_illegal      (err_illegal),
        .busy             (busy),
        .done             (done)
    );

    assign instruction_word = stack[read_pointer];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input opcode_t opc, input int a, input int b);
        stack[idx].opc  = opc;
        stack[idx].op_a = a;
        stack[idx].op_b = b;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!result_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!result_valid) chk("valid_timeout", 0, 1);
    endtask

    // Waits for a result, checks it, then steps one edge (a handshake when ready is high).
    task automatic expect_res(input string tag, input logic signed [63:0] exp_res,
                              input int exp_addr, input logic exp_div0, input logic exp_ill);
        int cyc;
        wait_valid(10, cyc);
        chk({tag, "_res"},   result, exp_res);
        chk({tag, "_addr"},  result_addr, exp_addr);
        chk({tag, "_rp"},    read_pointer, exp_addr);
        chk({tag, "_div0"},  err_div0, exp_div0);
        chk({tag, "_ill"},   err_illegal, exp_ill);
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, done, 1);
        tick();
        chk({tag, "_done_end"}, done, 0);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic start_run(input int first, input int cnt);
        first_addr = address_t'(first);
        count      = 6'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; first_addr = '0; count = '0; result_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) set_word(i, ZERO, 0, 0);
        tick(); tick();
        chk("rst_rp",    read_pointer, 0);
        chk("rst_res",   result, 0);
        chk("rst_raddr", result_addr, 0);
        chk("rst_vld",   result_valid, 0);
        chk("rst_div0",  err_div0, 0);
        chk("rst_ill",   err_illegal, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        reset = 1'b0;
        tick();

        // Basic three-instruction run with latency check.
        set_word(0, ADD, 5, 7);
        set_word(1, SUB, 3, 10);
        set_word(2, MULT, -4, 6);
        result_ready = 1'b1;
        start_run(0, 3);
        chk("t1_busy", busy, 1);
        wait_valid(10, cyc);
        chk("t1_latency", cyc, 2);
        expect_res("t1_r0", 12, 0, 0, 0);
        expect_res("t1_r1", -7, 1, 0, 0);
        expect_res("t1_r2", -24, 2, 0, 0);
        chk("t1_done", done, 1);
        chk("t1_busy_done", busy, 1);
        tick();
        chk("t1_done_end", done, 0);
        chk("t1_busy_end", busy, 0);

        // Backpressure holds result and pointer.
        set_word(0, PASSA, 9, 1);
        result_ready = 1'b0;
        start_run(0, 1);
        wait_valid(10, cyc);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_vld", result_valid, 1);
            chk("t2_hold_res", result, 9);
            chk("t2_hold_rp",  read_pointer, 0);
            tick();
        end
        result_ready = 1'b1;
        tick();
        chk("t2_vld_after", result_valid, 0);
        chk("t2_done", done, 1);
        tick();

        // Error cases.
        set_word(4, DIV, -15, 0);
        set_word(5, MOD, -15, 4);
        set_word(6, opcode_t'(4'hC), 1, 2);
        start_run(4, 3);
        expect_res("t3_div0", 0, 4, 1, 0);
        expect_res("t3_mod", -3, 5, 0, 0);
        expect_res("t3_ill", 0, 6, 0, 1);
        chk("t3_done", done, 1);
        tick();

        // Wrap-around of read_pointer.
        set_word(30, PASSA, 300, 0);
        set_word(31, PASSA, 310, 0);
        set_word(0, PASSB, 0, 77);
        set_word(1, DIV, -7, 2);
        start_run(30, 4);
        expect_res("t4_a30", 300, 30, 0, 0);
        expect_res("t4_a31", 310, 31, 0, 0);
        expect_res("t4_a0", 77, 0, 0, 0);
        expect_res("t4_a1", -3, 1, 0, 0);
        chk("t4_done", done, 1);
        tick();

        // count=0 goes straight to DONE.
        start_run(0, 0);
        chk("t5_zero_done", done, 1);
        chk("t5_zero_vld", result_valid, 0);
        tick();
        chk("t5_zero_done_end", done, 0);
        chk("t5_zero_busy_end", busy, 0);
        chk("t5_zero_vld_end", result_valid, 0);

        // start held into FETCH with a different count is ignored.
        set_word(0, ADD, 1, 1);
        set_word(1, ADD, 2, 2);
        first_addr = 5'd0; count = 6'd2; start = 1'b1;
        tick();
        first_addr = 5'd10; count = 6'd5;
        tick();
        start = 1'b0;
        expect_res("t5_r0", 2, 0, 0, 0);
        expect_res("t5_r1", 4, 1, 0, 0);
        chk("t5_done", done, 1);
        // start during the DONE cycle is ignored too.
        first_addr = 5'd0; count = 6'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_start_in_done", busy, 0);
        tick();
        chk("t5_still_idle", busy, 0);

        // Reset during OUT of the second of three instructions.
        set_word(0, PASSA, 11, 0);
        set_word(1, PASSA, 22, 0);
        set_word(2, PASSA, 33, 0);
        result_ready = 1'b1;
        start_run(0, 3);
        expect_res("t6_r0", 11, 0, 0, 0);
        result_ready = 1'b0;
        wait_valid(10, cyc);
        chk("t6_pre_rp", read_pointer, 1);
        reset = 1'b1;
        tick();
        chk("t6_rst_vld",  result_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rp",   read_pointer, 0);
        chk("t6_rst_done", done, 0);
        reset = 1'b0;
        result_ready = 1'b1;
        tick();
        chk("t6_no_done", done, 0);
        chk("t6_no_vld",  result_valid, 0);
        start_run(2, 1);
        expect_res("t6_fresh", 33, 2, 0, 0);
        chk("t6_fresh_done", done, 1);
        tick();
        chk("t6_fresh_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
